// File: rtl/decode_pkg.sv
// decode_pkg: mode encodings and the shared select-to-word decode function.
package decode_pkg;
  localparam logic [1:0] MODE_ONEHOT = 2'd0;
  localparam logic [1:0] MODE_THERMO = 2'd1;
  localparam logic [1:0] MODE_SCAN   = 2'd2;
  localparam logic [1:0] MODE_BLANK  = 2'd3;
  localparam int MAX_W = 64;
  // Returns {oor, d}; bits of d at or above out_w are always 0.
  function automatic logic [MAX_W:0] decode_word(input logic [5:0] sw, input logic [1:0] mode,
                                                 input logic [5:0] ptr, input int unsigned out_w);
    logic [MAX_W-1:0] d;
    logic oor;
    d = '0;
    oor = (mode == MODE_ONEHOT || mode == MODE_THERMO) && 32'(sw) >= out_w;
    for (int unsigned i = 0; i < MAX_W; i++)
      if (i < out_w)
        d[i] = mode == MODE_ONEHOT ? 6'(i) == sw :
               mode == MODE_THERMO ? 6'(i) <= sw :
               mode == MODE_SCAN   ? 6'(i) == ptr : 1'b0;
    return {oor, d};
  endfunction
endpackage

// File: rtl/decode_pipe_skid_buf.sv
// skid_buf: two-entry valid/ready register slice (output register plus one skid register).
module skid_buf #(
  parameter int W = 8,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic skid_valid;
  logic [W-1:0] skid_data;
  logic accept;
  logic load;
  assign in_ready = en & ~skid_valid;
  assign accept = in_valid & in_ready;
  assign load = ~out_valid | out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= INIT;
      skid_valid <= 1'b0;
      skid_data <= INIT;
    end else if (load) begin
      out_valid <= skid_valid | accept;
      out_data <= skid_valid ? skid_data : accept ? in_data : out_data;
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data <= in_data;
    end
  end
endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: registered binary decoder (onehot/thermo/scan/blank) with skid-buffered flow control.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int IN_W = 3,
  parameter int OUT_W = 8,
  parameter int ACTIVE_LOW = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  sw,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] code,
  output logic             oor,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int PW = $clog2(OUT_W);
  localparam logic INV = ACTIVE_LOW != 0;
  logic [PW-1:0] ptr;
  logic [MAX_W:0] word;
  logic [OUT_W-1:0] d;
  logic [OUT_W:0] held;
  logic accept;
  logic unused_bits;
  assign word = decode_word(6'(sw), mode, 6'(ptr), OUT_W);
  assign d = word[OUT_W-1:0];
  assign unused_bits = ^word;
  assign accept = in_valid & in_ready;
  assign {oor, code} = held;
  skid_buf #(
    .W(OUT_W + 1),
    .INIT({1'b0, {OUT_W{INV}}})
  ) u_skid (
    .clk(clk),
    .rst(RST),
    .en(en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data({word[MAX_W], INV ? ~d : d}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(held)
  );
  always_ff @(posedge clk) begin
    if (RST) begin
      ptr <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      if (mode == MODE_SCAN) ptr <= ptr == PW'(OUT_W - 1) ? '0 : ptr + 1'b1;
      if (word[MAX_W] && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: two decoder builds driven in lockstep against a queue-based reference model.
module tb_decode_pipe;
  logic clk = 1'b0;
  logic rst, en, in_valid, out_ready;
  logic [2:0] sw;
  logic [1:0] mode;
  logic in_ready_a, out_valid_a, oor_a, in_ready_b, out_valid_b, oor_b;
  logic [5:0] code_a;
  logic [2:0] err_a;
  logic [7:0] code_b, err_b;

  decode_pipe #(.IN_W(3), .OUT_W(6), .ACTIVE_LOW(0), .CNT_W(3)) dut_a (
    .clk(clk), .RST(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_a), .sw(sw), .mode(mode),
    .out_valid(out_valid_a), .out_ready(out_ready), .code(code_a), .oor(oor_a), .err_cnt(err_a));
  decode_pipe #(.IN_W(3), .OUT_W(8), .ACTIVE_LOW(1), .CNT_W(8)) dut_b (
    .clk(clk), .RST(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_b), .sw(sw), .mode(mode),
    .out_valid(out_valid_b), .out_ready(out_ready), .code(code_b), .oor(oor_b), .err_cnt(err_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ca;
    logic oa;
    logic [7:0] cb;
    logic ob;
  } beat_t;
  beat_t q[$];
  int pa, pb, ea, eb;
  bit fresh;
  int n_vec, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_code(input int w, input int s, input int m, input int p);
    case (m)
      0: return s < w ? 8'(1 << s) : 8'd0;
      1: return s < w ? 8'((1 << (s + 1)) - 1) : 8'((1 << w) - 1);
      2: return 8'(1 << p);
      default: return 8'd0;
    endcase
  endfunction

  // One clock: drive at negedge, model the edge, then check outputs at the next negedge.
  task automatic step(input logic v, input logic [2:0] s, input logic [1:0] m,
                      input logic r, input logic e, input logic rs);
    bit exp_ready, acc, xf;
    beat_t b;
    in_valid = v; sw = s; mode = m; out_ready = r; en = e; rst = rs;
    #1;
    exp_ready = e && q.size() < 2;
    check("in_ready_a", in_ready_a, exp_ready);
    check("in_ready_b", in_ready_b, exp_ready);
    if (rs) begin
      q.delete(); pa = 0; pb = 0; ea = 0; eb = 0; fresh = 1;
    end else begin
      acc = v && exp_ready;
      xf = q.size() > 0 && r;
      if (xf) void'(q.pop_front());
      if (acc) begin
        b.oa = m < 2 && s >= 6;
        b.ob = 1'b0;
        b.ca = 6'(ref_code(6, s, m, pa));
        b.cb = ~ref_code(8, s, m, pb);
        if (m == 2) begin pa = (pa + 1) % 6; pb = (pb + 1) % 8; end
        if (b.oa) ea = ea == 7 ? 7 : ea + 1;
        q.push_back(b);
        fresh = 0;
      end
    end
    @(negedge clk);
    check("out_valid_a", out_valid_a, q.size() > 0);
    check("out_valid_b", out_valid_b, q.size() > 0);
    check("err_cnt_a", err_a, ea);
    check("err_cnt_b", err_b, eb);
    if (q.size() > 0) begin
      check("code_a", code_a, q[0].ca);
      check("oor_a", oor_a, q[0].oa);
      check("code_b", code_b, q[0].cb);
      check("oor_b", oor_b, q[0].ob);
    end else if (fresh) begin
      check("rst_code_a", code_a, 6'h00);
      check("rst_code_b", code_b, 8'hFF);
      check("rst_oor", {oor_a, oor_b}, 2'b00);
    end
  endtask

  initial begin
    rst = 1; en = 1; in_valid = 0; out_ready = 1; sw = 0; mode = 0;
    repeat (2) @(negedge clk);
    repeat (4) step(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 3'(i), 2'd0, 1, 1, 0);
    step(1, 3, 2'd1, 1, 1, 0);
    step(1, 7, 2'd1, 1, 1, 0);
    step(1, 2, 2'd0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 3'(i + 1), 2'd0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 3'(i), (i % 4 == 3) ? 2'd0 : 2'd2, 1, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 3'(6 + i % 2), 2'(i % 2), 1, 1, 0);
    step(1, 1, 2'd0, 0, 1, 0);
    step(1, 2, 2'd2, 0, 1, 0);
    step(1, 3, 2'd0, 0, 1, 1);
    step(1, 4, 2'd2, 1, 1, 0);
    repeat (3) step(1, 5, 2'd0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom), 2'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 99) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
